sram_w8_64b_ctrl: RTL and testbench
===================================

# sram_w8_64b_ctrl

Request/response initiator that drives the single-port 8-entry x 64-bit SRAM macro (active-low CEN/WEN, 4-bit address, registered Q). Converts a valid/ready request stream (reads and writes) into SRAM strobes, tracks in-flight reads across the SRAM's one-cycle read latency, and returns read data in order through a 2-entry response FIFO with valid/ready backpressure. Sits between a core-side load/store agent and the SRAM instance.

## Interface
- DATA_W, 64, data width; matches SRAM word width
- ADDR_W, 4, SRAM address port width
- DEPTH, 8, number of implemented SRAM words; addresses >= DEPTH are out of range
- CLK  input  1  clock, all logic on posedge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid & req_ready
- req_wr  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  word address
- req_data  input  DATA_W  write data
- rsp_valid  output  1  read response present
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
- rsp_data  output  DATA_W  read data
- rsp_err  output  1  response is for an out-of-range address
- CEN  output  1  SRAM chip enable, active low
- WEN  output  1  SRAM write enable, active low (1 = read)
- A  output  ADDR_W  SRAM address
- D  output  DATA_W  SRAM write data
- Q  input  DATA_W  SRAM read data, valid the cycle after a read strobe

## Operation
- Accept = req_valid & req_ready. SRAM strobes are combinational from accept, same cycle: A = req_addr, D = req_data always; CEN = ~(accept & in_range); WEN = ~(accept & req_wr & in_range) (in_range = req_addr < DEPTH).
- No accept: CEN = 1, WEN = 1.
- Accepted write, in range: SRAM written at end of cycle; no response generated.
- Accepted write, out of range: dropped (CEN = 1), no response, no other side effect.
- Accepted read: sets in-flight stage (inflight = 1, err = ~in_range) for the next cycle. In that cycle the stage pushes {Q or 0 if err, err} into the response FIFO.
- Out-of-range read never strobes the SRAM; response data forced to 0, rsp_err = 1, order preserved.
- Response FIFO: 2 entries, in-order; head drives rsp_data/rsp_err; rsp_valid = FIFO non-empty.
- Credit rule: req_ready = ~reset & ((count + inflight - pop) < 2), pop = rsp_valid & rsp_ready. Combinational path rsp_ready -> req_ready is intended. req_ready does not depend on req_wr (writes gated identically; simplifies ordering).
- Credit guarantees the FIFO never overflows; push and pop in the same cycle with count = 2 cannot occur with push unless pop also occurs (count stays 2).
- Q sampled only in the in-flight cycle; stale Q in other cycles ignored.

## Timing
- Reset (synchronous, held >= 1 cycle): count = 0, inflight = 0; outputs during/after reset: req_ready = 0 during reset, rsp_valid = 0, rsp_data = 0, rsp_err = 0, CEN = 1, WEN = 1.
- First accept possible in the cycle after reset deasserts.
- Read latency: accept in cycle N -> rsp_valid in cycle N+2 (SRAM captures at end of N, Q valid N+1, FIFO write at end of N+1).
- Throughput: 1 read/cycle sustained while rsp_ready = 1; 1 write/cycle always (subject to credit).
- rsp_ready low: at most 2 reads outstanding (FIFO + in-flight); req_ready drops until a pop.
- rsp_valid/rsp_data/rsp_err stable while rsp_valid & ~rsp_ready.
- Read-after-write same address in consecutive cycles returns the new data.
- Reset mid-operation: in-flight read and FIFO contents discarded; no response emitted after reset; SRAM contents untouched.

## Test plan
- Write 0x1111_2222_3333_4444 to addr 3, read addr 3 next cycle -> CEN/WEN = 0/0 then 0/1; rsp_valid two cycles after read accept, rsp_data = 0x1111_2222_3333_4444, rsp_err = 0.
- Fill addrs 0-7 with value = addr*0x0101..., back-to-back reads 0-7 with rsp_ready = 1 -> req_ready never drops, 8 responses on consecutive cycles in order.
- Reads 0,1,2 with rsp_ready = 0 -> first two accepted, req_ready = 0 on third until rsp_ready = 1; third response correct after drain, no loss or duplicate.
- Read addr 9 and write addr 12 -> CEN stays 1 both; read response rsp_data = 0, rsp_err = 1; later read of all in-range words unchanged.
- Assert reset while 2 reads outstanding -> rsp_valid = 0, req_ready = 0 next cycle; no response after reset release; subsequent read returns pre-reset SRAM contents.

Source files
------------

// File: rtl/sram_w8_64b_ctrl.sv
// sram_w8_64b_ctrl: valid/ready front end for an 8 x 64-bit SRAM macro.
// One-cycle read pipeline and a 2-entry in-order response FIFO with credit.
module sram_w8_64b_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              CEN,
  output logic              WEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] Q
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic              in_range;
  logic              accept;
  logic              pop;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              inflight;
  logic              inflight_err;
  logic [DATA_W-1:0] fifo_data [2];
  logic              fifo_err  [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [2:0]        used;

  // Request side: credit check and same-cycle SRAM strobes
  always_comb begin
    in_range  = {1'b0, req_addr} < DEPTH_L;
    used      = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    req_ready = ~reset & (used < 3'd2);
    accept    = req_valid & req_ready;
    A         = req_addr;
    D         = req_data;
    CEN       = ~(accept & in_range);
    WEN       = ~(accept & req_wr & in_range);
  end

  // Response side: FIFO head, pop, and the in-flight push
  always_comb begin
    rsp_valid = (count != 2'd0);
    pop       = rsp_valid & rsp_ready;
    push      = inflight;
    push_data = inflight_err ? '0 : Q;
    rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
    rsp_err   = rsp_valid & fifo_err[rd_ptr];
  end

  // In-flight stage: one read waiting on the SRAM's registered Q
  always_ff @(posedge CLK) begin
    if (reset) begin
      inflight     <= 1'b0;
      inflight_err <= 1'b0;
    end else begin
      inflight     <= accept & ~req_wr;
      inflight_err <= ~in_range;
    end
  end

  // FIFO pointers and occupancy; credit prevents overflow
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // FIFO storage; output is masked while empty so no reset needed
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_err[wr_ptr]  <= inflight_err;
    end
  end

endmodule

// File: tb/tb_sram_w8_64b_ctrl.sv
// tb_sram_w8_64b_ctrl: self-checking bench with an SRAM model,
// a shadow memory and a response scoreboard queue.
module tb_sram_w8_64b_ctrl;

  logic        CLK = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [3:0]  req_addr;
  logic [63:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        CEN;
  logic        WEN;
  logic [3:0]  A;
  logic [63:0] D;
  logic [63:0] Q;

  sram_w8_64b_ctrl dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .CEN(CEN), .WEN(WEN), .A(A), .D(D), .Q(Q)
  );

  always #5 CLK = ~CLK;

  // SRAM macro model: write or registered read on posedge
  logic [63:0] mem [8];
  always @(posedge CLK) begin
    if (!CEN) begin
      if (!WEN) mem[A[2:0]] <= D;
      else      Q <= mem[A[2:0]];
    end
  end

  typedef struct {
    logic [63:0] d;
    logic        e;
  } rsp_t;

  typedef struct {
    bit          v;
    bit          wr;
    logic [3:0]  addr;
    logic [63:0] data;
    bit          rr;
    bit          cen;
    bit          wen;
  } vec_t;

  rsp_t        q[$];
  vec_t        tv[$];
  logic [63:0] shadow [8];
  bit          prev_rd;
  int          checks;
  int          errors;

  localparam logic [63:0] STEP = 64'h0101_0101_0101_0101;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit v, input bit wr, input logic [3:0] addr,
                      input logic [63:0] data, input bit rr,
                      output bit acc);
    bit   exp_valid;
    bit   exp_pop;
    bit   exp_ready;
    bit   inr;
    rsp_t e;
    rsp_t r;
    @(negedge CLK);
    req_valid = v;
    req_wr    = wr;
    req_addr  = addr;
    req_data  = data;
    rsp_ready = rr;
    #2;
    exp_valid = (q.size() - (prev_rd ? 1 : 0)) > 0;
    exp_pop   = exp_valid & rr;
    exp_ready = (q.size() - (exp_pop ? 1 : 0)) < 2;
    check("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_valid});
    check("req_ready", {63'd0, req_ready}, {63'd0, exp_ready});
    if (exp_pop) begin
      e = q.pop_front();
      check("rsp_data", rsp_data, e.d);
      check("rsp_err", {63'd0, rsp_err}, {63'd0, e.e});
    end
    acc = v & exp_ready;
    inr = addr < 4'd8;
    check("CEN", {63'd0, CEN}, {63'd0, !(acc & inr)});
    check("WEN", {63'd0, WEN}, {63'd0, !(acc & wr & inr)});
    if (acc && inr) check("A", {60'd0, A}, {60'd0, addr});
    if (acc && wr && inr) shadow[addr[2:0]] = data;
    if (acc && !wr) begin
      r.d = inr ? shadow[addr[2:0]] : 64'd0;
      r.e = !inr;
      q.push_back(r);
    end
    prev_rd = acc & ~wr;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset     = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    #2;
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_CEN", {63'd0, CEN}, 64'd1);
    check("rst_WEN", {63'd0, WEN}, 64'd1);
    @(negedge CLK);
    #2;
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    check("rst_req_ready2", {63'd0, req_ready}, 64'd0);
    @(negedge CLK);
    reset = 1'b0;
    q.delete();
    prev_rd = 1'b0;
  endtask

  task automatic drain(input string name);
    bit acc;
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      step(0, 0, 4'd0, 64'd0, 1, acc);
      n++;
    end
    check(name, 64'(q.size()), 64'd0);
  endtask

  function automatic vec_t mk(bit v, bit wr, logic [3:0] addr,
                              logic [63:0] data, bit rr, bit cen, bit wen);
    vec_t t;
    t.v = v; t.wr = wr; t.addr = addr; t.data = data;
    t.rr = rr; t.cen = cen; t.wen = wen;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int n;
    checks    = 0;
    errors    = 0;
    prev_rd   = 1'b0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = 4'd0;
    req_data  = 64'd0;
    rsp_ready = 1'b0;
    Q         = 64'd0;
    for (int i = 0; i < 8; i++) begin
      mem[i]    = 64'd0;
      shadow[i] = 64'd0;
    end

    tv.push_back(mk(1, 1, 4'd3, 64'h1111_2222_3333_4444, 1, 0, 0));
    tv.push_back(mk(1, 0, 4'd3, 64'd0, 1, 0, 1));
    tv.push_back(mk(0, 0, 4'd0, 64'd0, 1, 1, 1));
    tv.push_back(mk(0, 0, 4'd0, 64'd0, 1, 1, 1));
    for (int i = 0; i < 8; i++)
      tv.push_back(mk(1, 1, 4'(i), STEP * 64'(i), 1, 0, 0));
    for (int i = 0; i < 8; i++)
      tv.push_back(mk(1, 0, 4'(i), 64'd0, 1, 0, 1));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0, 0, 4'd0, 64'd0, 1, 1, 1));
    tv.push_back(mk(1, 0, 4'd9, 64'd0, 1, 1, 1));
    tv.push_back(mk(1, 1, 4'd12, 64'hdead_beef_dead_beef, 1, 1, 1));
    for (int i = 0; i < 8; i++)
      tv.push_back(mk(1, 0, 4'(i), 64'd0, 1, 0, 1));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0, 0, 4'd0, 64'd0, 1, 1, 1));

    do_reset();

    foreach (tv[i]) begin
      step(tv[i].v, tv[i].wr, tv[i].addr, tv[i].data, tv[i].rr, acc);
      check($sformatf("tbl%0d_CEN", i), {63'd0, CEN}, {63'd0, tv[i].cen});
      check($sformatf("tbl%0d_WEN", i), {63'd0, WEN}, {63'd0, tv[i].wen});
    end
    drain("tbl_drain");

    step(1, 0, 4'd0, 64'd0, 0, acc);
    check("bp_acc0", {63'd0, acc}, 64'd1);
    step(1, 0, 4'd1, 64'd0, 0, acc);
    check("bp_acc1", {63'd0, acc}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 4'd2, 64'd0, 0, acc);
      check("bp_stall", {63'd0, acc}, 64'd0);
    end
    n = 0;
    acc = 1'b0;
    while (!acc && n < 10) begin
      step(1, 0, 4'd2, 64'd0, 1, acc);
      n++;
    end
    check("bp_third_accepted", {63'd0, acc}, 64'd1);
    drain("bp_drain");

    step(1, 0, 4'd5, 64'd0, 0, acc);
    step(1, 0, 4'd6, 64'd0, 0, acc);
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 4'd0, 64'd0, 1, acc);
    step(1, 0, 4'd5, 64'd0, 1, acc);
    step(1, 0, 4'd6, 64'd0, 1, acc);
    drain("rst_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
